// File: rtl/gray_counter.sv
// Synchronous up/down Gray-code counter with parallel load and wrap/saturate ends.
// The binary count and its Gray code are registered together on the same edge.
module gray_counter #(
  parameter int WIDTH    = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap,
  output logic             at_limit
);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             at_limit_q, at_limit_d;

  always_comb begin
    bin_d      = bin_q;
    wrap_d     = 1'b0;
    at_limit_d = at_limit_q;
    if (load) begin
      bin_d      = load_val;
      at_limit_d = 1'b0;
    end else if (en) begin
      if (up) begin
        if (bin_q == MAX) begin
          if (SATURATE) begin
            at_limit_d = 1'b1;
          end else begin
            bin_d      = '0;
            wrap_d     = 1'b1;
            at_limit_d = 1'b0;
          end
        end else begin
          bin_d      = bin_q + ONE;
          at_limit_d = 1'b0;
        end
      end else begin
        if (bin_q == '0) begin
          if (SATURATE) begin
            at_limit_d = 1'b1;
          end else begin
            bin_d      = MAX;
            wrap_d     = 1'b1;
            at_limit_d = 1'b0;
          end
        end else begin
          bin_d      = bin_q - ONE;
          at_limit_d = 1'b0;
        end
      end
    end
    // Encode from the next binary value so gray lands on the same edge as bin.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q      <= '0;
      gray_q     <= '0;
      wrap_q     <= 1'b0;
      at_limit_q <= 1'b0;
    end else begin
      bin_q      <= bin_d;
      gray_q     <= gray_d;
      wrap_q     <= wrap_d;
      at_limit_q <= at_limit_d;
    end
  end

  assign bin      = bin_q;
  assign gray     = gray_q;
  assign wrap     = wrap_q;
  assign at_limit = at_limit_q;

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter: vector table on 3-bit wrap/saturate instances,
// plus full up/down sweeps on 2-, 4- and 8-bit instances.
module tb_gray_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Directed 3-bit instances share one set of inputs.
  logic       d_rst = 1'b1, d_load = 1'b0, d_en = 1'b0, d_up = 1'b0;
  logic [2:0] d_lv = '0;
  logic [2:0] w_bin, w_gray, s_bin, s_gray;
  logic       w_wrap, w_at, s_wrap, s_at;

  gray_counter #(.WIDTH(3), .SATURATE(1'b0)) u_w3 (
    .clk(clk), .rst(d_rst), .en(d_en), .up(d_up), .load(d_load), .load_val(d_lv),
    .bin(w_bin), .gray(w_gray), .wrap(w_wrap), .at_limit(w_at));

  gray_counter #(.WIDTH(3), .SATURATE(1'b1)) u_s3 (
    .clk(clk), .rst(d_rst), .en(d_en), .up(d_up), .load(d_load), .load_val(d_lv),
    .bin(s_bin), .gray(s_gray), .wrap(s_wrap), .at_limit(s_at));

  // Sweep instances: shared reset/direction, private enables.
  logic       sw_rst = 1'b1, sw_up = 1'b1, sw_load = 1'b0;
  logic       en2 = 1'b0, en4 = 1'b0, en8 = 1'b0;
  logic [1:0] bin2, gray2;
  logic [3:0] bin4, gray4;
  logic [7:0] bin8, gray8;
  logic       wrap2, wrap4, wrap8, at2, at4, at8;

  gray_counter #(.WIDTH(2)) u_w2 (
    .clk(clk), .rst(sw_rst), .en(en2), .up(sw_up), .load(sw_load), .load_val(2'b0),
    .bin(bin2), .gray(gray2), .wrap(wrap2), .at_limit(at2));

  gray_counter #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(sw_rst), .en(en4), .up(sw_up), .load(sw_load), .load_val(4'b0),
    .bin(bin4), .gray(gray4), .wrap(wrap4), .at_limit(at4));

  gray_counter #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(sw_rst), .en(en8), .up(sw_up), .load(sw_load), .load_val(8'b0),
    .bin(bin8), .gray(gray8), .wrap(wrap8), .at_limit(at8));

  typedef struct {
    logic       sat;
    logic       rst, load, en, up;
    logic [2:0] lv;
    logic [2:0] eb, eg;
    logic       ew, ea;
    string      name;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic sat, input logic rst, input logic load, input logic en,
                     input logic up, input logic [2:0] lv, input logic [2:0] eb,
                     input logic [2:0] eg, input logic ew, input logic ea, input string name);
    vec_t v;
    v.sat = sat; v.rst = rst; v.load = load; v.en = en; v.up = up; v.lv = lv;
    v.eb = eb; v.eg = eg; v.ew = ew; v.ea = ea; v.name = name;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic sweep(input int w);
    logic [15:0] mask, m, prev, ob, og;
    logic        ow, ew;
    int          n, wraps;
    mask = 16'((32'd1 << w) - 1);
    n    = (1 << w) + 1;
    @(negedge clk);
    sw_rst = 1'b1; en2 = 1'b0; en4 = 1'b0; en8 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    sw_rst = 1'b0;
    m = '0; prev = '0;
    for (int dir = 1; dir >= 0; dir--) begin
      wraps = 0;
      for (int s = 0; s < n; s++) begin
        @(negedge clk);
        sw_up = dir[0];
        en2 = (w == 2); en4 = (w == 4); en8 = (w == 8);
        @(posedge clk); #1;
        case (w)
          2:       begin ob = 16'(bin2); og = 16'(gray2); ow = wrap2; end
          4:       begin ob = 16'(bin4); og = 16'(gray4); ow = wrap4; end
          default: begin ob = 16'(bin8); og = 16'(gray8); ow = wrap8; end
        endcase
        if (dir == 1) begin
          ew = (m == mask);
          m  = (m + 16'd1) & mask;
        end else begin
          ew = (m == 16'd0);
          m  = (m - 16'd1) & mask;
        end
        chk($sformatf("sweep w%0d bin", w), ob, m);
        chk($sformatf("sweep w%0d gray", w), og, m ^ (m >> 1));
        chk($sformatf("sweep w%0d onebit", w), 16'($countones(og ^ prev)), 16'd1);
        chk($sformatf("sweep w%0d wrap", w), 16'(ow), 16'(ew));
        wraps += int'(ow);
        prev = og;
      end
      chk($sformatf("sweep w%0d wraps dir%0d", w, dir), 16'(wraps), 16'd1);
    end
    @(negedge clk);
    en2 = 1'b0; en4 = 1'b0; en8 = 1'b0;
  endtask

  initial begin
    // Wrap instance: reset, full up count
    add(0, 1,0,0,0, 3'd0, 3'd0, 3'b000, 0, 0, "w reset");
    add(0, 0,0,1,1, 3'd0, 3'd1, 3'b001, 0, 0, "w up1");
    add(0, 0,0,1,1, 3'd0, 3'd2, 3'b011, 0, 0, "w up2");
    add(0, 0,0,1,1, 3'd0, 3'd3, 3'b010, 0, 0, "w up3");
    add(0, 0,0,1,1, 3'd0, 3'd4, 3'b110, 0, 0, "w up4");
    add(0, 0,0,1,1, 3'd0, 3'd5, 3'b111, 0, 0, "w up5");
    add(0, 0,0,1,1, 3'd0, 3'd6, 3'b101, 0, 0, "w up6");
    add(0, 0,0,1,1, 3'd0, 3'd7, 3'b100, 0, 0, "w up7");
    add(0, 0,0,1,1, 3'd0, 3'd0, 3'b000, 1, 0, "w up wrap");
    // Down wrap from 0
    add(0, 1,0,0,0, 3'd0, 3'd0, 3'b000, 0, 0, "w reset2");
    add(0, 0,0,1,0, 3'd0, 3'd7, 3'b100, 1, 0, "w down wrap");
    add(0, 0,0,1,0, 3'd0, 3'd6, 3'b101, 0, 0, "w down6");
    // Load beats en; then hold
    add(0, 0,1,1,1, 3'd5, 3'd5, 3'b111, 0, 0, "w load5");
    add(0, 0,0,1,1, 3'd0, 3'd6, 3'b101, 0, 0, "w after load");
    add(0, 0,0,0,1, 3'd0, 3'd6, 3'b101, 0, 0, "w hold");
    // Reset mid-count beats load and en
    add(0, 1,0,0,0, 3'd0, 3'd0, 3'b000, 0, 0, "w reset3");
    add(0, 0,0,1,1, 3'd0, 3'd1, 3'b001, 0, 0, "w rc1");
    add(0, 0,0,1,1, 3'd0, 3'd2, 3'b011, 0, 0, "w rc2");
    add(0, 0,0,1,1, 3'd0, 3'd3, 3'b010, 0, 0, "w rc3");
    add(0, 0,0,1,1, 3'd0, 3'd4, 3'b110, 0, 0, "w rc4");
    add(0, 1,1,1,1, 3'd3, 3'd0, 3'b000, 0, 0, "w rst+load");
    add(0, 0,0,1,1, 3'd0, 3'd1, 3'b001, 0, 0, "w resume");
    // Back-to-back wraps by alternating direction at the boundary
    add(0, 1,0,0,0, 3'd0, 3'd0, 3'b000, 0, 0, "w reset4");
    add(0, 0,0,1,0, 3'd0, 3'd7, 3'b100, 1, 0, "w bb1");
    add(0, 0,0,1,1, 3'd0, 3'd0, 3'b000, 1, 0, "w bb2");
    add(0, 0,0,1,0, 3'd0, 3'd7, 3'b100, 1, 0, "w bb3");
    add(0, 0,0,0,0, 3'd0, 3'd7, 3'b100, 0, 0, "w bb hold");
    // Load at MAX with en up: no wrap
    add(0, 0,1,0,0, 3'd7, 3'd7, 3'b100, 0, 0, "w load7");
    add(0, 0,1,1,1, 3'd0, 3'd0, 3'b000, 0, 0, "w load0 at max");
    // Saturate instance
    add(1, 1,0,0,0, 3'd0, 3'd0, 3'b000, 0, 0, "s reset");
    add(1, 0,1,0,0, 3'd6, 3'd6, 3'b101, 0, 0, "s load6");
    add(1, 0,0,1,1, 3'd0, 3'd7, 3'b100, 0, 0, "s up7");
    add(1, 0,0,1,1, 3'd0, 3'd7, 3'b100, 0, 1, "s sat1");
    add(1, 0,0,1,1, 3'd0, 3'd7, 3'b100, 0, 1, "s sat2");
    add(1, 0,0,0,1, 3'd0, 3'd7, 3'b100, 0, 1, "s hold limit");
    add(1, 0,0,1,0, 3'd0, 3'd6, 3'b101, 0, 0, "s down6");
    add(1, 1,0,0,0, 3'd0, 3'd0, 3'b000, 0, 0, "s reset2");
    add(1, 0,0,1,0, 3'd0, 3'd0, 3'b000, 0, 1, "s sat low1");
    add(1, 0,0,1,0, 3'd0, 3'd0, 3'b000, 0, 1, "s sat low2");
    add(1, 0,0,0,0, 3'd0, 3'd0, 3'b000, 0, 1, "s hold low");
    add(1, 0,1,1,0, 3'd2, 3'd2, 3'b011, 0, 0, "s load2");
    add(1, 0,0,1,1, 3'd0, 3'd3, 3'b010, 0, 0, "s up3");
    add(1, 0,0,1,0, 3'd0, 3'd2, 3'b011, 0, 0, "s down2");
    add(1, 1,1,1,1, 3'd5, 3'd0, 3'b000, 0, 0, "s rst+load");

    d_rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      d_rst = tbl[i].rst; d_load = tbl[i].load; d_en = tbl[i].en;
      d_up  = tbl[i].up;  d_lv   = tbl[i].lv;
      @(posedge clk); #1;
      if (tbl[i].sat) begin
        chk({tbl[i].name, " bin"},  16'(s_bin),  16'(tbl[i].eb));
        chk({tbl[i].name, " gray"}, 16'(s_gray), 16'(tbl[i].eg));
        chk({tbl[i].name, " wrap"}, 16'(s_wrap), 16'(tbl[i].ew));
        chk({tbl[i].name, " lim"},  16'(s_at),   16'(tbl[i].ea));
      end else begin
        chk({tbl[i].name, " bin"},  16'(w_bin),  16'(tbl[i].eb));
        chk({tbl[i].name, " gray"}, 16'(w_gray), 16'(tbl[i].eg));
        chk({tbl[i].name, " wrap"}, 16'(w_wrap), 16'(tbl[i].ew));
        chk({tbl[i].name, " lim"},  16'(w_at),   16'(tbl[i].ea));
      end
    end

    @(negedge clk);
    d_en = 1'b0; d_load = 1'b0; d_rst = 1'b0;

    sweep(2);
    sweep(4);
    sweep(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
